button_pulse_shaper: RTL and testbench

//  Inverse of the 1 s pulse extender: compresses a raw, bouncy, arbitrarily long button level into clean

---
 rtl/alarm_ui_pkg.sv | 24 ++
 rtl/sync_2ff.sv | 25 ++
 rtl/button_pulse_shaper.sv | 141 ++++++++++++++
 tb/tb_button_pulse_shaper.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/alarm_ui_pkg.sv
// Shared alarm-clock UI definitions: counter width and button FSM state encodings.
// Imported by the button shaper and the other UI setting FSMs.
package alarm_ui_pkg;

   localparam int CNT_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_DEB_PRESS = 3'd1,
      ST_PRESSED   = 3'd2,
      ST_REPEAT    = 3'd3,
      ST_DEB_REL   = 3'd4
   } ui_state_e;

   function automatic logic [CNT_W-1:0] to_cnt(input int v);
      return v[CNT_W-1:0];
   endfunction

   // Debounced level is high from the accepted press until the release is accepted.
   function automatic logic is_held_state(input ui_state_e s);
      return (s == ST_PRESSED) || (s == ST_REPEAT) || (s == ST_DEB_REL);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchronizer with synchronous active-high reset,
// used on every raw button pin entering the clk_100Hz domain.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/button_pulse_shaper.sv
// Debounces a raw button and turns each accepted press into a single-cycle pulse.
// Define BUTTON_AUTOREPEAT_EN to auto-repeat pulses while the button is held.
module button_pulse_shaper
   import alarm_ui_pkg::*;
#(
   parameter int DEBOUNCE_TICKS = 3,
   parameter int REPEAT_DELAY   = 100,
   parameter int REPEAT_PERIOD  = 20
) (
   input  logic clk_100Hz,
   input  logic rst,
   input  logic signal,
   output logic pulse,
   output logic held
);

   localparam logic [CNT_W-1:0] L_DEB = to_cnt(DEBOUNCE_TICKS);
   localparam logic [CNT_W-1:0] L_ONE = to_cnt(1);

   ui_state_e        r_state;
   ui_state_e        w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_pulse;
   logic             r_held;
   logic             w_pulse_nxt;
   logic             w_held_nxt;
   logic             w_sync_in;

`ifdef BUTTON_AUTOREPEAT_EN
   localparam logic [CNT_W-1:0] L_RD_LAST = to_cnt(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] L_RP_LAST = to_cnt(REPEAT_PERIOD - 1);
`else
   logic w_unused_cfg;
   assign w_unused_cfg = ^{to_cnt(REPEAT_DELAY), to_cnt(REPEAT_PERIOD)};
`endif

   sync_2ff u_sync (
      .clk (clk_100Hz),
      .rst (rst),
      .i_d (signal),
      .o_q (w_sync_in)
   );

   always_ff @(posedge clk_100Hz) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_pulse <= 1'b0;
         r_held  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_pulse <= w_pulse_nxt;
         r_held  <= w_held_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            w_cnt_nxt = '0;
            if (w_sync_in) begin
               w_state_nxt = ST_DEB_PRESS;
               w_cnt_nxt   = L_ONE;
            end
         end
         ST_DEB_PRESS: begin
            if (!w_sync_in) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end else if (r_cnt == L_DEB) begin
               w_state_nxt = ST_PRESSED;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + L_ONE;
            end
         end
         ST_PRESSED: begin
            if (!w_sync_in) begin
               w_state_nxt = ST_DEB_REL;
               w_cnt_nxt   = L_ONE;
`ifdef BUTTON_AUTOREPEAT_EN
            end else if (r_cnt == L_RD_LAST) begin
               w_state_nxt = ST_REPEAT;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + L_ONE;
`endif
            end
         end
`ifdef BUTTON_AUTOREPEAT_EN
         ST_REPEAT: begin
            if (!w_sync_in) begin
               w_state_nxt = ST_DEB_REL;
               w_cnt_nxt   = L_ONE;
            end else if (r_cnt == L_RP_LAST) begin
               w_cnt_nxt = '0;
            end else begin
               w_cnt_nxt = r_cnt + L_ONE;
            end
         end
`endif
         ST_DEB_REL: begin
            // A bounce back high re-enters PRESSED with a fresh repeat delay.
            if (w_sync_in) begin
               w_state_nxt = ST_PRESSED;
               w_cnt_nxt   = '0;
            end else if (r_cnt == L_DEB) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + L_ONE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_comb begin
      w_pulse_nxt = 1'b0;
      case (r_state)
         ST_DEB_PRESS: w_pulse_nxt = w_sync_in && (r_cnt == L_DEB);
`ifdef BUTTON_AUTOREPEAT_EN
         ST_PRESSED:   w_pulse_nxt = w_sync_in && (r_cnt == L_RD_LAST);
         ST_REPEAT:    w_pulse_nxt = w_sync_in && (r_cnt == L_RP_LAST);
`endif
         default:      w_pulse_nxt = 1'b0;
      endcase
      w_held_nxt = is_held_state(w_state_nxt);
   end

   assign pulse = r_pulse;
   assign held  = r_held;

endmodule

// File: tb/tb_button_pulse_shaper.sv
// Directed bench for button_pulse_shaper: scenario/checkpoint tables plus a bounce sequence.
// Expectations follow the build's BUTTON_AUTOREPEAT_EN setting.
module tb_button_pulse_shaper;

`ifdef BUTTON_AUTOREPEAT_EN
   localparam logic AR = 1'b1;
`else
   localparam logic AR = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   logic signal;
   logic pulse;
   logic held;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      int hi_from;
      int hi_to;
      int low_at;
      int rst_at;
      int n_edges;
      int exp_pulses;
   } scn_t;

   typedef struct {
      int   scn;
      int   edge_no;
      logic exp_pulse;
      logic exp_held;
   } chk_t;

   scn_t scn[4];
   chk_t chk[$];

   button_pulse_shaper #(
      .DEBOUNCE_TICKS (3),
      .REPEAT_DELAY   (100),
      .REPEAT_PERIOD  (20)
   ) dut (
      .clk_100Hz (clk),
      .rst       (rst),
      .signal    (signal),
      .pulse     (pulse),
      .held      (held)
   );

   always #5 clk = ~clk;

   task automatic check_bit(input string name, input int e, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at edge %0d: got %b, expected %b", name, e, act, exp);
      end
   endtask

   task automatic check_val(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic void add(input int s, input int e, input logic p, input logic h);
      chk_t c;
      c.scn = s; c.edge_no = e; c.exp_pulse = p; c.exp_held = h;
      chk.push_back(c);
   endfunction

   task automatic do_reset();
      rst    = 1'b1;
      signal = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic run_scn(input int s);
      int   pulses = 0;
      int   b2b    = 0;
      logic prev   = 1'b0;
      do_reset();
      check_bit($sformatf("s%0d_reset_pulse", s), 0, pulse, 1'b0);
      check_bit($sformatf("s%0d_reset_held", s), 0, held, 1'b0);
      for (int e = 1; e <= scn[s].n_edges; e++) begin
         signal = (e >= scn[s].hi_from) && (e <= scn[s].hi_to) && (e != scn[s].low_at);
         rst    = (e == scn[s].rst_at);
         @(posedge clk);
         #1;
         if (pulse === 1'b1) begin
            pulses++;
            if (prev === 1'b1) b2b++;
         end
         prev = pulse;
         foreach (chk[i]) begin
            if (chk[i].scn == s && chk[i].edge_no == e) begin
               check_bit($sformatf("s%0d_pulse", s), e, pulse, chk[i].exp_pulse);
               check_bit($sformatf("s%0d_held", s), e, held, chk[i].exp_held);
            end
         end
      end
      rst    = 1'b0;
      signal = 1'b0;
      check_val($sformatf("s%0d_pulse_count", s), pulses, scn[s].exp_pulses);
      check_val($sformatf("s%0d_back_to_back_pulses", s), b2b, 0);
   endtask

   initial begin
      int bounce_pulses;
      int bounce_held;
      rst    = 1'b1;
      signal = 1'b0;

      // Glitch too short to debounce.
      scn[0] = '{10, 11, -1, -1, 40, 0};
      // Long hold: one pulse, or 11 with auto-repeat.
      scn[1] = '{10, 299, -1, -1, 320, AR ? 11 : 1};
      // One-cycle drop mid-hold: held survives, repeat delay restarts at edge 53.
      scn[2] = '{10, 200, 50, -1, 220, AR ? 4 : 1};
      // Reset mid-press with the button still down: treated as a new press.
      scn[3] = '{10, 100, -1, 40, 120, 2};

      add(0, 11, 1'b0, 1'b0); add(0, 14, 1'b0, 1'b0); add(0, 15, 1'b0, 1'b0);

      add(1, 14, 1'b0, 1'b0);  add(1, 15, 1'b1, 1'b1);  add(1, 16, 1'b0, 1'b1);
      add(1, 114, 1'b0, 1'b1); add(1, 115, AR, 1'b1);   add(1, 116, 1'b0, 1'b1);
      add(1, 135, AR, 1'b1);   add(1, 295, AR, 1'b1);   add(1, 304, 1'b0, 1'b1);
      add(1, 305, 1'b0, 1'b0);

      add(2, 15, 1'b1, 1'b1);  add(2, 52, 1'b0, 1'b1);  add(2, 53, 1'b0, 1'b1);
      add(2, 54, 1'b0, 1'b1);  add(2, 115, 1'b0, 1'b1); add(2, 153, AR, 1'b1);
      add(2, 173, AR, 1'b1);   add(2, 193, AR, 1'b1);   add(2, 205, 1'b0, 1'b1);
      add(2, 206, 1'b0, 1'b0);

      add(3, 15, 1'b1, 1'b1);  add(3, 39, 1'b0, 1'b1);  add(3, 40, 1'b0, 1'b0);
      add(3, 41, 1'b0, 1'b0);  add(3, 45, 1'b0, 1'b0);  add(3, 46, 1'b1, 1'b1);
      add(3, 47, 1'b0, 1'b1);  add(3, 105, 1'b0, 1'b1); add(3, 106, 1'b0, 1'b0);

      for (int s = 0; s < 4; s++) run_scn(s);

      // Alternating 1-high/1-low bounce never survives debounce.
      do_reset();
      bounce_pulses = 0;
      bounce_held   = 0;
      for (int e = 1; e <= 40; e++) begin
         signal = e[0];
         @(posedge clk);
         #1;
         if (pulse !== 1'b0) bounce_pulses++;
         if (held !== 1'b0) bounce_held++;
      end
      signal = 1'b0;
      check_val("bounce_pulse_cycles", bounce_pulses, 0);
      check_val("bounce_held_cycles", bounce_held, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
